amount_display: RTL and testbench

Converts a binary millilitre amount into four active-low seven-segment digit patterns for the board's HEX displays. It is the display-side counterpart of the water dispenser's keypad entry: the dispenser packs decimal digits from the switches into a binary total, and this block unpacks that total back into decimal digits. It uses an iterative shift-and-add-3 (double-dabble) converter with a request/done handshake. It sits between the dispenser's `total_amount_in_ml` output and the HEX0–HEX3 pins.

---
 rtl/amount_display_if.sv | 41 ++++
 rtl/amount_display.sv | 187 ++++++++++++++++++
 tb/tb_amount_display.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/amount_display_if.sv
// Request/done bus between a requester and the amount_display converter.
// Handshake: the requester raises update_request (sampled every rising clock edge); the
// converter answers with busy while working and a one-cycle done when the HEX outputs
// take their new values. Requests seen while busy collapse into a single follow-up.
interface amount_display_if #(
    parameter int INPUT_BIT_COUNT = 14
);
    logic [INPUT_BIT_COUNT-1:0] amount_in_ml;
    logic                       update_request;
    logic                       busy;
    logic                       done;
    logic [6:0]                 hex0;
    logic [6:0]                 hex1;
    logic [6:0]                 hex2;
    logic [6:0]                 hex3;
    logic [1:0]                 state_dbg;

    modport master (
        output amount_in_ml,
        output update_request,
        input  busy,
        input  done,
        input  hex0,
        input  hex1,
        input  hex2,
        input  hex3,
        input  state_dbg
    );

    modport slave (
        input  amount_in_ml,
        input  update_request,
        output busy,
        output done,
        output hex0,
        output hex1,
        output hex2,
        output hex3,
        output state_dbg
    );
endinterface

// File: rtl/amount_display.sv
// Binary millilitre amount to four active-low seven-segment digits via iterative double-dabble.
// Optional leading-zero blanking is enabled by defining AMOUNT_DISPLAY_BLANK_EN.
module amount_display #(
    parameter int          INPUT_BIT_COUNT      = 14,
    parameter int unsigned MAXIMUM_VOLUME_IN_ML = 9999
) (
    input logic             clock,
    input logic             reset,
    amount_display_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CONVERTING = 2'd1,
        COMMIT     = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(INPUT_BIT_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INPUT_BIT_COUNT - 1);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
`ifdef AMOUNT_DISPLAY_BLANK_EN
    localparam logic [6:0] HEX_UPPER_RESET = SEG_BLANK;
`else
    localparam logic [6:0] HEX_UPPER_RESET = SEG_ZERO;
`endif

    state_t                     state;
    logic [INPUT_BIT_COUNT-1:0] bin_q;
    logic [15:0]                bcd_q;
    logic [CNT_W-1:0]           cnt_q;
    logic                       overflow_q;
    logic                       pending_q;
    logic                       busy_q;
    logic                       done_q;
    logic [6:0]                 hex0_q;
    logic [6:0]                 hex1_q;
    logic [6:0]                 hex2_q;
    logic [6:0]                 hex3_q;

    logic [15:0]                   bcd_adj;
    logic [16+INPUT_BIT_COUNT-1:0] shift_cat;
    logic                          start;
    logic                          overflow_in;
    logic [6:0]                    seg0;
    logic [6:0]                    seg1;
    logic [6:0]                    seg2;
    logic [6:0]                    seg3;

    function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // One double-dabble step: correct nibbles >= 5, then shift {bcd, binary} left.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        shift_cat = {bcd_adj, bin_q} << 1;
    end

    always_comb begin
        start = 1'b0;
        if (state == IDLE) begin
            start = bus.update_request;
        end else if (state == COMMIT) begin
            start = pending_q | bus.update_request;
        end
    end

    assign overflow_in = 32'(bus.amount_in_ml) > 32'(MAXIMUM_VOLUME_IN_ML);

    // Segment patterns for the finished conversion; only registered in COMMIT.
    always_comb begin
        seg0 = digit_to_seg(bcd_q[3:0]);
        seg1 = digit_to_seg(bcd_q[7:4]);
        seg2 = digit_to_seg(bcd_q[11:8]);
        seg3 = digit_to_seg(bcd_q[15:12]);
`ifdef AMOUNT_DISPLAY_BLANK_EN
        if (bcd_q[15:12] == 4'd0) begin
            seg3 = SEG_BLANK;
            if (bcd_q[11:8] == 4'd0) begin
                seg2 = SEG_BLANK;
                if (bcd_q[7:4] == 4'd0) begin
                    seg1 = SEG_BLANK;
                end
            end
        end
`endif
        if (overflow_q) begin
            seg0 = SEG_DASH;
            seg1 = SEG_DASH;
            seg2 = SEG_DASH;
            seg3 = SEG_DASH;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            pending_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hex0_q     <= SEG_ZERO;
            hex1_q     <= HEX_UPPER_RESET;
            hex2_q     <= HEX_UPPER_RESET;
            hex3_q     <= HEX_UPPER_RESET;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_q      <= bus.amount_in_ml;
                        bcd_q      <= '0;
                        cnt_q      <= '0;
                        overflow_q <= overflow_in;
                        busy_q     <= 1'b1;
                        state      <= CONVERTING;
                    end
                end
                CONVERTING: begin
                    bcd_q <= shift_cat[16+INPUT_BIT_COUNT-1:INPUT_BIT_COUNT];
                    bin_q <= shift_cat[INPUT_BIT_COUNT-1:0];
                    cnt_q <= cnt_q + 1'b1;
                    if (bus.update_request) begin
                        pending_q <= 1'b1;
                    end
                    if (cnt_q == CNT_LAST) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    hex0_q <= seg0;
                    hex1_q <= seg1;
                    hex2_q <= seg2;
                    hex3_q <= seg3;
                    done_q <= 1'b1;
                    if (start) begin
                        // Chained follow-up: busy stays high across the commit.
                        bin_q      <= bus.amount_in_ml;
                        bcd_q      <= '0;
                        cnt_q      <= '0;
                        overflow_q <= overflow_in;
                        pending_q  <= 1'b0;
                        state      <= CONVERTING;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.hex0      = hex0_q;
    assign bus.hex1      = hex1_q;
    assign bus.hex2      = hex2_q;
    assign bus.hex3      = hex3_q;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_amount_display.sv
// Directed bench for amount_display: hand-computed segment words, latency and handshake checks.
module tb_amount_display;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] DSH = 7'b0111111;
    localparam logic [6:0] BLK = 7'b1111111;
`ifdef AMOUNT_DISPLAY_BLANK_EN
    localparam logic [6:0] BZ = BLK;
`else
    localparam logic [6:0] BZ = S0;
`endif

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;
    logic [27:0] exp_q[$];

    amount_display_if #(.INPUT_BIT_COUNT(14)) bus ();

    amount_display #(
        .INPUT_BIT_COUNT(14),
        .MAXIMUM_VOLUME_IN_ML(9999)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [27:0] hex_word();
        return {bus.hex3, bus.hex2, bus.hex1, bus.hex0};
    endfunction

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (bus.done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic expect_commit(input string tag);
        logic [27:0] e;
        check({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(tag, 32'(hex_word()), 32'(e));
        end
    endtask

    // Drive a request at the negedge; returns after the negedge following the sampling edge.
    task automatic send_request(input logic [13:0] amt);
        @(negedge clock);
        bus.amount_in_ml   = amt;
        bus.update_request = 1'b1;
        @(negedge clock);
        bus.update_request = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic [13:0] amt,
                           input logic [6:0] e3, input logic [6:0] e2,
                           input logic [6:0] e1, input logic [6:0] e0);
        logic [27:0] prev;
        int n;
        prev = hex_word();
        exp_q.push_back({e3, e2, e1, e0});
        send_request(amt);
        check({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
        repeat (7) @(negedge clock);
        check({tag, "_hex_stable"}, 32'(hex_word()), 32'(prev));
        wait_done(n);
        check({tag, "_latency"}, 32'(n + 7), 32'd15);
        expect_commit(tag);
        check({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
        @(negedge clock);
        check({tag, "_done_width"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int n;
        int dones;
        n_checks = 0;
        n_errors = 0;
        bus.amount_in_ml   = '0;
        bus.update_request = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_state", 32'(bus.state_dbg), 32'd0);
        check("rst_hex", 32'(hex_word()), 32'({BZ, BZ, BZ, S0}));
        reset = 1'b0;
        repeat (2) @(negedge clock);

        run_vec("v1234", 14'd1234, S1, S2, S3, S4);
        run_vec("v7", 14'd7, BZ, BZ, BZ, S7);
        run_vec("v9999", 14'd9999, S9, S9, S9, S9);
        run_vec("v10000", 14'd10000, DSH, DSH, DSH, DSH);
        run_vec("v0", 14'd0, BZ, BZ, BZ, S0);
        run_vec("v16383", 14'd16383, DSH, DSH, DSH, DSH);
        run_vec("v1000", 14'd1000, S1, S0, S0, S0);
        run_vec("v50", 14'd50, BZ, BZ, S5, S0);

        // Two requests while busy collapse into a single follow-up conversion.
        exp_q.push_back({BZ, BZ, S4, S2});
        exp_q.push_back({BZ, S8, S0, S5});
        send_request(14'd42);
        repeat (4) @(negedge clock);
        bus.amount_in_ml   = 14'd805;
        bus.update_request = 1'b1;
        @(negedge clock);
        bus.update_request = 1'b0;
        repeat (2) @(negedge clock);
        bus.update_request = 1'b1;
        @(negedge clock);
        bus.update_request = 1'b0;
        wait_done(n);
        check("chain_first_latency", 32'(n + 8), 32'd15);
        expect_commit("chain_first");
        check("chain_busy_held", 32'(bus.busy), 32'd1);
        wait_done(n);
        check("chain_second_latency", 32'(n), 32'd15);
        expect_commit("chain_second");
        check("chain_busy_fall", 32'(bus.busy), 32'd0);
        dones = 0;
        repeat (30) begin
            @(negedge clock);
            if (bus.done) dones++;
        end
        check("chain_no_third", 32'(dones), 32'd0);

        // Held-high request restarts after every commit.
        for (int k = 0; k < 3; k++) exp_q.push_back({BZ, S3, S2, S1});
        bus.amount_in_ml   = 14'd321;
        @(negedge clock);
        bus.update_request = 1'b1;
        @(negedge clock);
        wait_done(n);
        check("hold_first_latency", 32'(n), 32'd15);
        expect_commit("hold_first");
        wait_done(n);
        check("hold_period", 32'(n), 32'd15);
        expect_commit("hold_second");
        check("hold_busy", 32'(bus.busy), 32'd1);
        bus.update_request = 1'b0;
        wait_done(n);
        check("hold_last_latency", 32'(n), 32'd15);
        expect_commit("hold_last");
        check("hold_busy_fall", 32'(bus.busy), 32'd0);

        // Reset mid-conversion with a pending request queued.
        send_request(14'd5555);
        repeat (3) @(negedge clock);
        bus.update_request = 1'b1;
        @(negedge clock);
        bus.update_request = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_hex", 32'(hex_word()), 32'({BZ, BZ, BZ, S0}));
        @(negedge clock);
        reset = 1'b0;
        dones = 0;
        n = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.done) dones++;
            if (bus.busy) n++;
        end
        check("midrst_no_done", 32'(dones), 32'd0);
        check("midrst_no_busy", 32'(n), 32'd0);
        check("midrst_state", 32'(bus.state_dbg), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
